// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit, 8-register MIPS pipeline.
// Pure types and constants; no logic, no latency, no flow control.
// Consumers import with mips16_pkg::*.
package mips16_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_R    = 4'h0;
  localparam opcode_t OP_ADDI = 4'h1;
  localparam opcode_t OP_LW   = 4'h2;
  localparam opcode_t OP_SW   = 4'h3;
  localparam opcode_t OP_BEQ  = 4'h4;

  // Instruction field positions: opcode | rs | rt | rd | funct, imm overlays rd|funct.
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 5;
  localparam int IMM_W     = 6;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RT   = 2'd2
  } dest_sel_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      illegal;
    logic      uses_rt;
    dest_sel_t dest_sel;
  } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Opcode to control-bundle lookup for the ID stage.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its valid.
module id_decoder
  import mips16_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
             illegal: 1'b0, uses_rt: 1'b0, dest_sel: DEST_NONE};
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.dest_sel  = DEST_RD;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.dest_sel  = DEST_RT;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.dest_sel  = DEST_RT;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.uses_rt   = 1'b1;
      end
      default: begin
        ctrl.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode with writeback bypass, load-use bubble and ID/EX register.
// One cycle from acceptance to ex_*.
// if_ready drops on load-use hazard, external stall or reset; stall holds ID/EX.
module id_stage
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] read_register_1,
  output logic [ADDR_W-1:0] read_register_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_register,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_illegal,
  output logic [3:0]        ex_opcode,
  output logic [2:0]        ex_funct,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [CNT_W-1:0]  stall_count
);

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [2:0]        funct;
  logic [DATA_W-1:0] imm;
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              hazard;

  assign opcode = if_instr[OP_MSB:OP_LSB];
  assign rs     = if_instr[RS_MSB:RS_LSB];
  assign rt     = if_instr[RT_MSB:RT_LSB];
  assign rd     = if_instr[RD_MSB:RD_LSB];
  assign funct  = if_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm    = {{(DATA_W-IMM_W){if_instr[IMM_MSB]}}, if_instr[IMM_MSB:0]};

  assign read_register_1 = rs;
  assign read_register_2 = rt;

  id_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  always_comb begin
    dest = '0;
    case (ctrl.dest_sel)
      DEST_RD: dest = rd;
      DEST_RT: dest = rt;
      default: dest = '0;
    endcase
  end

  // RegisterFile's write lands on the next edge, so same-cycle writes are forwarded here.
  assign rs_data = (wb_reg_write && (wb_write_register == rs)) ? wb_write_data : read_data_1;
  assign rt_data = (wb_reg_write && (wb_write_register == rt)) ? wb_write_data : read_data_2;

  assign hazard = if_valid & ex_valid & ex_mem_read &
                  ((ex_dest == rs) | (ctrl.uses_rt & (ex_dest == rt)));

  assign if_ready = !hazard && !stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_dest      <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      stall_count  <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!stall) begin
      if (hazard) begin
        // The LW moves on next cycle, clearing ex_mem_read, so one bubble suffices.
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_illegal   <= 1'b0;
        if (stall_count != {CNT_W{1'b1}}) begin
          stall_count <= stall_count + 1'b1;
        end
      end else begin
        ex_valid     <= if_valid;
        ex_reg_write <= if_valid & ctrl.reg_write;
        ex_mem_read  <= if_valid & ctrl.mem_read;
        ex_mem_write <= if_valid & ctrl.mem_write;
        ex_illegal   <= if_valid & ctrl.illegal;
        ex_opcode    <= opcode;
        ex_funct     <= funct;
        ex_dest      <= dest;
        ex_rs_data   <= rs_data;
        ex_rt_data   <= rt_data;
        ex_imm       <= imm;
        ex_pc        <= if_pc;
      end
    end
  end

endmodule
